// File: rtl/dpr_loader_pkg.sv
// Shared definitions for the command-memory loader: words per command,
// loader state encoding and the start-range check.
package dpr_loader_pkg;

  localparam int MEM_TO_CMD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } loader_state_e;

  // True when the requested load would run past the top of the address space.
  // Evaluated wide so a large n_cmds cannot wrap the sum back into range.
  function automatic logic range_err(input logic [31:0] addr,
                                     input logic [31:0] n,
                                     input int unsigned aw);
    logic [33:0] sum;
    logic [33:0] lim;
    sum = {2'b00, addr} + {2'b00, n};
    lim = 34'd1 << aw;
    return (sum > lim);
  endfunction

endpackage

// File: rtl/cmd_mem_loader_word_packer.sv
// Assembles MEM_TO_CMD host words into one command, first word least significant.
// full_o pulses combinationally with the push that completes a command.
module word_packer
  import dpr_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int CMD_WIDTH  = MEM_TO_CMD * WORD_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic [CMD_WIDTH-1:0]  cmd_o,
  output logic                  full_o
);

  localparam int               IDX_W    = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_TO_CMD - 1);
  localparam int               SH_W     = CMD_WIDTH - WORD_WIDTH;

  logic [SH_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Words enter at the top and slide down, so word 0 ends up in the LSBs.
  assign cmd_o  = {word_i, shift_q};
  assign full_o = push_i && (idx_q == LAST_IDX);

  // Next-state for the shift register and word index.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (push_i) begin
      shift_d = cmd_o[CMD_WIDTH-1:WORD_WIDTH];
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      shift_d = shift_q;
      idx_d   = idx_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/cmd_mem_loader.sv
// Host-side loader: packs host words into commands, writes them to consecutive
// command-memory addresses and holds the processor in reset while loading.
module cmd_mem_loader
  import dpr_loader_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int CMD_WIDTH      = MEM_TO_CMD * WORD_WIDTH,
  parameter int CMD_ADDR_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [CMD_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [CMD_ADDR_WIDTH:0]   n_cmds_i,
  input  logic                      abort_i,
  input  logic [WORD_WIDTH-1:0]     word_i,
  input  logic                      word_valid_i,
  output logic                      word_ready_o,
  output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr_o,
  output logic [CMD_WIDTH-1:0]      cmd_write_o,
  output logic                      cmd_write_enable_o,
  output logic                      proc_reset_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      addr_err_o
);

  localparam int CNT_W = CMD_ADDR_WIDTH + 1;

  loader_state_e             state_q, state_d;
  logic [CMD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CMD_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CMD_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                      we_q, we_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      proc_rst_q, proc_rst_d;

  logic                      push_s;
  logic                      pk_clear_s;
  logic                      full_s;
  logic [CMD_WIDTH-1:0]      packed_s;

  // An abort in the same cycle as a word throws that word away with the rest.
  assign push_s     = (state_q == ST_LOAD) && ready_q && word_valid_i && !abort_i;
  assign pk_clear_s = (state_q != ST_LOAD) || abort_i;

  word_packer #(
    .WORD_WIDTH (WORD_WIDTH),
    .CMD_WIDTH  (CMD_WIDTH)
  ) u_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (pk_clear_s),
    .push_i  (push_s),
    .word_i  (word_i),
    .cmd_o   (packed_s),
    .full_o  (full_s)
  );

  // Loader FSM next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    proc_rst_d = proc_rst_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (n_cmds_i == '0) begin
            done_d     = 1'b1;
            proc_rst_d = 1'b0;
          end else if (range_err(32'(start_addr_i), 32'(n_cmds_i), CMD_ADDR_WIDTH)) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_LOAD;
            addr_d     = start_addr_i;
            cnt_d      = n_cmds_i;
            err_d      = 1'b0;
            proc_rst_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (full_s) begin
          wr_addr_d = addr_q;
          wr_data_d = packed_s;
          we_d      = 1'b1;
          addr_d    = addr_q + CMD_ADDR_WIDTH'(1);
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        if (abort_i) begin
          done_d = 1'b0;
        end else begin
          done_d     = 1'b1;
          proc_rst_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  // Loader state and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      proc_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      proc_rst_q <= proc_rst_d;
    end
  end

  assign word_ready_o       = ready_q;
  assign cmd_write_addr_o   = wr_addr_q;
  assign cmd_write_o        = wr_data_q;
  assign cmd_write_enable_o = we_q;
  assign proc_reset_o       = proc_rst_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign addr_err_o         = err_q;

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Directed bench for cmd_mem_loader: a table of load scenarios plus hand-written
// abort and mid-load reset sequences.
module tb_cmd_mem_loader;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [7:0]   start_addr_i;
  logic [8:0]   n_cmds_i;
  logic         abort_i;
  logic [31:0]  word_i;
  logic         word_valid_i;
  logic         word_ready_o;
  logic [7:0]   cmd_write_addr_o;
  logic [127:0] cmd_write_o;
  logic         cmd_write_enable_o;
  logic         proc_reset_o;
  logic         busy_o;
  logic         done_o;
  logic         addr_err_o;

  cmd_mem_loader dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .start_addr_i       (start_addr_i),
    .n_cmds_i           (n_cmds_i),
    .abort_i            (abort_i),
    .word_i             (word_i),
    .word_valid_i       (word_valid_i),
    .word_ready_o       (word_ready_o),
    .cmd_write_addr_o   (cmd_write_addr_o),
    .cmd_write_o        (cmd_write_o),
    .cmd_write_enable_o (cmd_write_enable_o),
    .proc_reset_o       (proc_reset_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .addr_err_o         (addr_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]   addr;
    logic [127:0] data;
    int           c;
  } wr_t;

  typedef struct {
    logic [7:0]  sa;
    logic [8:0]  n;
    logic [31:0] base;
    logic [31:0] step;
    bit          gaps;
    int          mid;
    bit          err;
    int          exp_writes;
    int          exp_done;
    int          exp_lat;
  } vec_t;

  wr_t  wr_q[$];
  int   xfer_q[$];
  int   done_cnt = 0;
  int   done_cyc = -1;
  logic proc_at_done = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[9];

  // Monitor sampling shortly after each rising edge.
  always begin
    @(posedge clk_i);
    #2;
    if (cmd_write_enable_o) wr_q.push_back('{cmd_write_addr_o, cmd_write_o, cyc});
    if (done_o) begin
      done_cnt++;
      done_cyc     = cyc;
      proc_at_done = proc_reset_o;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_word_ready"}, word_ready_o, 1'b0);
    chk({tag, "_wr_addr"}, cmd_write_addr_o, 8'h00);
    chk({tag, "_wr_data"}, cmd_write_o, 128'h0);
    chk({tag, "_wr_en"}, cmd_write_enable_o, 1'b0);
    chk({tag, "_proc_reset"}, proc_reset_o, 1'b1);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_addr_err"}, addr_err_o, 1'b0);
  endtask

  function automatic logic [127:0] model_cmd(input logic [31:0] base, input logic [31:0] step, input int c);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = base + step * 32'(4 * c + j);
    return r;
  endfunction

  // Pulses start, then offers `words` words; returns in the cycle after the last transfer.
  task automatic load(input logic [7:0] sa, input logic [8:0] n, input logic [31:0] base,
                      input logic [31:0] step, input bit gaps, input int words,
                      input int mid, output int s_cyc);
    int k;
    int guard;
    k = 0;
    guard = 0;
    xfer_q.delete();
    @(negedge clk_i);
    start_i      = 1'b1;
    start_addr_i = sa;
    n_cmds_i     = n;
    s_cyc        = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    while (k < words && guard < 4000) begin
      if (k == mid) begin
        start_i      = 1'b1;
        start_addr_i = 8'h00;
        n_cmds_i     = 9'd1;
      end else begin
        start_i = 1'b0;
      end
      word_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      word_i       = base + step * 32'(k);
      if (word_valid_i && word_ready_o) begin
        k++;
        if (k % 4 == 0) xfer_q.push_back(cyc);
      end
      @(negedge clk_i);
      guard++;
    end
    start_i      = 1'b0;
    word_valid_i = 1'b0;
    chk("words_transferred", k, words);
  endtask

  task automatic scenario(input string tag, input vec_t v);
    int s;
    int d0;
    int g;
    int nw;
    logic [7:0] ea;
    wr_q.delete();
    d0 = done_cnt;
    load(v.sa, v.n, v.base, v.step, v.gaps, v.err ? 0 : 4 * int'(v.n), v.mid, s);
    chk({tag, "_addr_err"}, addr_err_o, v.err);
    chk({tag, "_word_ready"}, word_ready_o, 1'b0);
    chk({tag, "_busy"}, busy_o, (v.n != 9'd0) && !v.err);
    if (v.n != 9'd0 && !v.err) chk({tag, "_proc_reset_held"}, proc_reset_o, 1'b1);
    g = 0;
    while (v.exp_done != 0 && done_cnt == d0 && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    repeat (3) @(negedge clk_i);
    chk({tag, "_done_count"}, done_cnt - d0, v.exp_done);
    if (v.exp_done != 0) chk({tag, "_proc_reset_at_done"}, proc_at_done, 1'b0);
    if (v.exp_lat != 0) chk({tag, "_done_latency"}, done_cyc - s, v.exp_lat);
    chk({tag, "_write_count"}, wr_q.size(), v.exp_writes);
    nw = (wr_q.size() < v.exp_writes) ? wr_q.size() : v.exp_writes;
    for (int i = 0; i < nw; i++) begin
      ea = v.sa + 8'(i);
      chk({tag, "_wr_addr"}, wr_q[i].addr, ea);
      chk({tag, "_wr_data"}, wr_q[i].data, model_cmd(v.base, v.step, i));
      if (i < xfer_q.size()) chk({tag, "_wr_cycle"}, wr_q[i].c, xfer_q[i] + 1);
    end
  endtask

  initial begin
    int s;
    int d0;
    vec_t spec1;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    start_addr_i = 8'h00;
    n_cmds_i     = 9'd0;
    abort_i      = 1'b0;
    word_i       = 32'h0;
    word_valid_i = 1'b0;

    spec1   = '{8'h10, 9'd1,   32'h11111111, 32'h11111111, 1'b0, -1, 1'b0, 1,   1, 6};
    vecs[0] = '{8'hFE, 9'd3,   32'hB0000000, 32'h00000001, 1'b0, -1, 1'b1, 0,   0, 0};
    vecs[1] = '{8'hFD, 9'd3,   32'hA0000000, 32'h00000001, 1'b1, -1, 1'b0, 3,   1, 0};
    vecs[2] = '{8'h00, 9'd0,   32'h00000000, 32'h00000001, 1'b0, -1, 1'b0, 0,   1, 1};
    vecs[3] = '{8'hFF, 9'd1,   32'h5A5A0000, 32'h01010101, 1'b0, -1, 1'b0, 1,   1, 6};
    vecs[4] = '{8'hFF, 9'd2,   32'h00000000, 32'h00000001, 1'b0, -1, 1'b1, 0,   0, 0};
    vecs[5] = '{8'h01, 9'h100, 32'h00000000, 32'h00000001, 1'b0, -1, 1'b1, 0,   0, 0};
    vecs[6] = '{8'h50, 9'd2,   32'hC0000000, 32'h00000003, 1'b0, 3,  1'b0, 2,   1, 10};
    vecs[7] = '{8'h00, 9'h100, 32'h12340000, 32'h00000001, 1'b0, -1, 1'b0, 256, 1, 1026};
    vecs[8] = '{8'h80, 9'd1,   32'hDEAD0000, 32'h00000010, 1'b1, -1, 1'b0, 1,   1, 0};

    #1;
    chk_reset("rst_asserted");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset("rst_released");

    scenario("single", spec1);
    if (wr_q.size() > 0)
      chk("single_spec_data", wr_q[0].data, 128'h44444444_33333333_22222222_11111111);
    else
      chk("single_spec_present", wr_q.size(), 1);

    for (int i = 0; i < 9; i++) scenario($sformatf("vec%0d", i), vecs[i]);

    // Abort after six words of a two-command load.
    wr_q.delete();
    d0 = done_cnt;
    load(8'h40, 9'd2, 32'hC0DE0000, 32'h00000001, 1'b0, 6, -1, s);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_word_ready", word_ready_o, 1'b0);
    repeat (6) @(negedge clk_i);
    chk("abort_write_count", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      chk("abort_wr_addr", wr_q[0].addr, 8'h40);
      chk("abort_wr_data", wr_q[0].data, model_cmd(32'hC0DE0000, 32'h1, 0));
    end
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_proc_reset", proc_reset_o, 1'b1);

    // Asynchronous reset after the second word of a load.
    load(8'h60, 9'd1, 32'h77770000, 32'h00000001, 1'b0, 2, -1, s);
    rst_i = 1'b1;
    #1;
    chk_reset("rst_midload");
    @(negedge clk_i);
    rst_i = 1'b0;
    scenario("after_reset", '{8'h60, 9'd1, 32'h99990000, 32'h00000101, 1'b0, -1, 1'b0, 1, 1, 6});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
